// File: rtl/intr_ctrl85_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl85_pkg
// Brief    : Shared types, restart vectors and SIM/RIM bit positions for the
//            8085 interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package intr_ctrl85_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SRC_NONE = 3'd0,
      SRC_TRAP = 3'd1,
      SRC_R75  = 3'd2,
      SRC_R65  = 3'd3,
      SRC_R55  = 3'd4,
      SRC_INTR = 3'd5
   } src_t;

   localparam logic [15:0] c_VEC_TRAP = 16'h0024;
   localparam logic [15:0] c_VEC_R75  = 16'h003C;
   localparam logic [15:0] c_VEC_R65  = 16'h0034;
   localparam logic [15:0] c_VEC_R55  = 16'h002C;

   localparam int c_SIM_MSE = 3;
   localparam int c_SIM_R75 = 4;
   localparam int c_SIM_SDE = 6;
   localparam int c_SIM_SOD = 7;

   // INTR has no restart vector; the core fetches the opcode through INTA.
   function automatic logic [15:0] src_vec(input src_t s);
      case (s)
         SRC_TRAP: return c_VEC_TRAP;
         SRC_R75:  return c_VEC_R75;
         SRC_R65:  return c_VEC_R65;
         SRC_R55:  return c_VEC_R55;
         default:  return 16'h0000;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/intr_ctrl85_if.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl85_if
// Brief    : Handshake between the 8085 control FSM (master) and the
//            interrupt controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface intr_ctrl85_if #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 16
) ();
   logic                poll;
   logic                ack;
   logic                ei_op;
   logic                di_op;
   logic                sim_wr;
   logic [DATASIZE-1:0] sim_data;
   logic                irq;
   logic                use_inta;
   logic [ADDRSIZE-1:0] ivec;
   logic [DATASIZE-1:0] rim_data;
   logic                ie_out;

   modport master (
      output poll, ack, ei_op, di_op, sim_wr, sim_data,
      input  irq, use_inta, ivec, rim_data, ie_out
   );

   modport slave (
      input  poll, ack, ei_op, di_op, sim_wr, sim_data,
      output irq, use_inta, ivec, rim_data, ie_out
   );
endinterface
`default_nettype wire

// File: rtl/intr_ctrl85_edge_latch.sv
`default_nettype none
// ============================================================================
// Module   : edge_latch85
// Brief    : Pin synchroniser, rising-edge detector and set/clear latch used
//            for TRAP and RST7.5. A rising edge wins over a same-cycle clear.
// Revision : 1.0 - initial release
// ============================================================================
module edge_latch85 #(
   parameter int SYNC_STAGES = 2
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic pin,
   input  wire logic clr,
   output logic      lvl,
   output logic      latch
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_latch;
   logic                   w_rise;

   assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync  <= '0;
         r_prev  <= 1'b0;
         r_latch <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pin};
         r_prev <= r_sync[SYNC_STAGES-1];
         if (w_rise)
            r_latch <= 1'b1;
         else if (clr)
            r_latch <= 1'b0;
      end
   end

   assign lvl   = r_sync[SYNC_STAGES-1];
   assign latch = r_latch;
endmodule
`default_nettype wire

// File: rtl/intr_ctrl85.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl85
// Brief    : 8085 interrupt controller: pin sync, SIM masks/IE, fixed-priority
//            arbitration and request/vector handshake. Define SERIAL_IO_EN to
//            enable SID/SOD.
// Revision : 1.0 - initial release
// ============================================================================
module intr_ctrl85
   import intr_ctrl85_pkg::*;
#(
   parameter int DATASIZE    = 8,
   parameter int ADDRSIZE    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          trap,
   input  wire logic          rst75,
   input  wire logic          rst65,
   input  wire logic          rst55,
   input  wire logic          intr,
   input  wire logic          sid,
   output logic               sod,
   intr_ctrl85_if.slave       cpu
);
   state_t              r_state, w_state_nxt;
   src_t                r_win, w_win;
   logic [ADDRSIZE-1:0] r_vec;
   logic                r_use_inta;
   logic                r_ie, r_ei_pend, r_ie_trap, r_trap_seen;
   logic                r_m75, r_m65, r_m55;
   logic                r_sod;
   logic                w_capture, w_done;
   logic                w_trap_lvl, w_trap_latch, w_r75_latch, w_r75_lvl_unused;
   logic                w_trap_clr, w_r75_clr;
   logic [2:0]          r_lvl_sync [SYNC_STAGES];
   logic                w_lvl65, w_lvl55, w_lvlintr;
   logic                w_sid_s;
   logic [7:0]          w_rim;

   assign w_trap_clr = w_done && (r_win == SRC_TRAP);
   assign w_r75_clr  = (w_done && (r_win == SRC_R75)) ||
                       (cpu.sim_wr && cpu.sim_data[c_SIM_R75]);

   edge_latch85 #(.SYNC_STAGES(SYNC_STAGES)) u_trap (
      .clk   (clk),
      .rst   (rst),
      .pin   (trap),
      .clr   (w_trap_clr),
      .lvl   (w_trap_lvl),
      .latch (w_trap_latch)
   );

   edge_latch85 #(.SYNC_STAGES(SYNC_STAGES)) u_r75 (
      .clk   (clk),
      .rst   (rst),
      .pin   (rst75),
      .clr   (w_r75_clr),
      .lvl   (w_r75_lvl_unused),
      .latch (w_r75_latch)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++)
            r_lvl_sync[k] <= 3'b000;
      end else begin
         r_lvl_sync[0] <= {rst65, rst55, intr};
         for (int k = 1; k < SYNC_STAGES; k++)
            r_lvl_sync[k] <= r_lvl_sync[k-1];
      end
   end

   assign {w_lvl65, w_lvl55, w_lvlintr} = r_lvl_sync[SYNC_STAGES-1];

`ifdef SERIAL_IO_EN
   logic [SYNC_STAGES-1:0] r_sid_sync;
   logic                   w_unused;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_sid_sync <= '0;
      else
         r_sid_sync <= {r_sid_sync[SYNC_STAGES-2:0], sid};
   end

   assign w_sid_s  = r_sid_sync[SYNC_STAGES-1];
   assign w_unused = cpu.sim_data[5];
`else
   // Pins kept for footprint compatibility only.
   logic [3:0] w_unused;

   assign w_sid_s  = 1'b0;
   assign w_unused = {sid, cpu.sim_data[7:5]};
`endif

   // Fixed priority; maskable sources also require IE as it stood before this poll.
   always_comb begin
      w_win = SRC_NONE;
      if (w_trap_latch && w_trap_lvl)
         w_win = SRC_TRAP;
      else if (w_r75_latch && !r_m75 && r_ie)
         w_win = SRC_R75;
      else if (w_lvl65 && !r_m65 && r_ie)
         w_win = SRC_R65;
      else if (w_lvl55 && !r_m55 && r_ie)
         w_win = SRC_R55;
      else if (w_lvlintr && r_ie)
         w_win = SRC_INTR;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cpu.poll && (w_win != SRC_NONE)) begin
               w_state_nxt = ST_REQ;
               w_capture   = 1'b1;
            end
         end
         ST_REQ: begin
            if (cpu.ack)
               w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_win      <= SRC_NONE;
         r_vec      <= '0;
         r_use_inta <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_win      <= w_win;
            r_vec      <= ADDRSIZE'(src_vec(w_win));
            r_use_inta <= (w_win == SRC_INTR);
         end
      end
   end

   // DI overrides a same-cycle EI; a pending EI takes effect at the next poll.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ie        <= 1'b0;
         r_ei_pend   <= 1'b0;
         r_ie_trap   <= 1'b0;
         r_trap_seen <= 1'b0;
      end else begin
         if (cpu.di_op) begin
            r_ie      <= 1'b0;
            r_ei_pend <= 1'b0;
         end else begin
            if (w_done)
               r_ie <= 1'b0;
            else if (cpu.poll && r_ei_pend)
               r_ie <= 1'b1;
            if (cpu.poll && r_ei_pend)
               r_ei_pend <= 1'b0;
            if (cpu.ei_op)
               r_ei_pend <= 1'b1;
         end

         if (cpu.ei_op || cpu.di_op)
            r_trap_seen <= 1'b0;
         else if (w_done && (r_win == SRC_TRAP)) begin
            r_trap_seen <= 1'b1;
            r_ie_trap   <= r_ie;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m75 <= 1'b1;
         r_m65 <= 1'b1;
         r_m55 <= 1'b1;
         r_sod <= 1'b0;
      end else if (cpu.sim_wr) begin
         if (cpu.sim_data[c_SIM_MSE])
            {r_m75, r_m65, r_m55} <= cpu.sim_data[2:0];
`ifdef SERIAL_IO_EN
         if (cpu.sim_data[c_SIM_SDE])
            r_sod <= cpu.sim_data[c_SIM_SOD];
`endif
      end
   end

   assign w_rim = {w_sid_s, w_r75_latch, w_lvl65, w_lvl55,
                   (r_trap_seen ? r_ie_trap : r_ie), r_m75, r_m65, r_m55};

   assign cpu.irq      = (r_state == ST_REQ);
   assign cpu.use_inta = r_use_inta;
   assign cpu.ivec     = r_vec;
   assign cpu.rim_data = DATASIZE'(w_rim);
   assign cpu.ie_out   = r_ie;
   assign sod          = r_sod;
endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl85.sv
`default_nettype none
// ============================================================================
// Module   : tb_intr_ctrl85
// Brief    : Directed self-checking bench for intr_ctrl85.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intr_ctrl85;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic trap = 1'b0, rst75 = 1'b0, rst65 = 1'b0, rst55 = 1'b0, intr = 1'b0;
   logic sid = 1'b0;
   logic sod;
   int   n_tests = 0;
   int   n_fail  = 0;

   intr_ctrl85_if #(.DATASIZE(8), .ADDRSIZE(16)) bus ();

   intr_ctrl85 #(.DATASIZE(8), .ADDRSIZE(16), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .trap  (trap),
      .rst75 (rst75),
      .rst65 (rst65),
      .rst55 (rst55),
      .intr  (intr),
      .sid   (sid),
      .sod   (sod),
      .cpu   (bus)
   );

   always #5 clk = ~clk;

`ifdef SERIAL_IO_EN
   localparam logic c_SER = 1'b1;
`else
   localparam logic c_SER = 1'b0;
`endif

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_poll();
      bus.poll = 1'b1; tick(1); bus.poll = 1'b0;
   endtask

   task automatic do_ack();
      bus.ack = 1'b1; tick(1); bus.ack = 1'b0;
   endtask

   task automatic do_ei();
      bus.ei_op = 1'b1; tick(1); bus.ei_op = 1'b0;
   endtask

   task automatic do_di();
      bus.di_op = 1'b1; tick(1); bus.di_op = 1'b0;
   endtask

   task automatic do_sim(input logic [7:0] d);
      bus.sim_data = d; bus.sim_wr = 1'b1; tick(1); bus.sim_wr = 1'b0; bus.sim_data = 8'h00;
   endtask

   task automatic test_reset();
      n_tests++; if (bus.irq !== 1'b0) begin $display("FAIL reset_irq: got %b expected 0", bus.irq); n_fail++; end
      n_tests++; if (bus.use_inta !== 1'b0) begin $display("FAIL reset_use_inta: got %b expected 0", bus.use_inta); n_fail++; end
      n_tests++; if (bus.ivec !== 16'h0000) begin $display("FAIL reset_ivec: got %h expected 0000", bus.ivec); n_fail++; end
      n_tests++; if (bus.ie_out !== 1'b0) begin $display("FAIL reset_ie: got %b expected 0", bus.ie_out); n_fail++; end
      n_tests++; if (bus.rim_data !== 8'h07) begin $display("FAIL reset_rim: got %h expected 07", bus.rim_data); n_fail++; end
      n_tests++; if (sod !== 1'b0) begin $display("FAIL reset_sod: got %b expected 0", sod); n_fail++; end
      rst55 = 1'b1; tick(4);
      do_poll();
      n_tests++; if (bus.irq !== 1'b0) begin $display("FAIL ie0_no_irq: got %b expected 0", bus.irq); n_fail++; end
      n_tests++; if (bus.rim_data !== 8'h17) begin $display("FAIL rim_pending55: got %h expected 17", bus.rim_data); n_fail++; end
      rst55 = 1'b0; tick(4);
   endtask

   task automatic test_rst65();
      do_sim(8'h08);
      do_ei();
      do_poll();
      n_tests++; if (bus.ie_out !== 1'b1) begin $display("FAIL ei_applied: got %b expected 1", bus.ie_out); n_fail++; end
      do_poll();
      rst65 = 1'b1; tick(4);
      do_poll();
      n_tests++; if (bus.irq !== 1'b1) begin $display("FAIL r65_irq: got %b expected 1", bus.irq); n_fail++; end
      n_tests++; if (bus.ivec !== 16'h0034) begin $display("FAIL r65_ivec: got %h expected 0034", bus.ivec); n_fail++; end
      n_tests++; if (bus.use_inta !== 1'b0) begin $display("FAIL r65_use_inta: got %b expected 0", bus.use_inta); n_fail++; end
      do_poll();
      n_tests++; if (bus.irq !== 1'b1 || bus.ivec !== 16'h0034) begin $display("FAIL req_hold_on_poll: got irq=%b ivec=%h expected irq=1 ivec=0034", bus.irq, bus.ivec); n_fail++; end
      rst65 = 1'b0; tick(3);
      n_tests++; if (bus.irq !== 1'b1) begin $display("FAIL level_drop_req: got %b expected 1", bus.irq); n_fail++; end
      do_ack();
      n_tests++; if (bus.irq !== 1'b0) begin $display("FAIL r65_ack_irq: got %b expected 0", bus.irq); n_fail++; end
      tick(1);
      n_tests++; if (bus.ie_out !== 1'b0) begin $display("FAIL r65_ack_ie: got %b expected 0", bus.ie_out); n_fail++; end
   endtask

   task automatic test_priority();
      do_ei(); do_poll();
      trap = 1'b1; rst75 = 1'b1; intr = 1'b1; tick(4);
      do_poll();
      n_tests++; if (bus.irq !== 1'b1 || bus.ivec !== 16'h0024) begin $display("FAIL trap_win: got irq=%b ivec=%h expected irq=1 ivec=0024", bus.irq, bus.ivec); n_fail++; end
      do_ack(); tick(1);
      n_tests++; if (bus.rim_data !== 8'h48) begin $display("FAIL rim_after_trap: got %h expected 48", bus.rim_data); n_fail++; end
      n_tests++; if (bus.ie_out !== 1'b0) begin $display("FAIL trap_clears_ie: got %b expected 0", bus.ie_out); n_fail++; end
      do_ei(); do_poll();
      n_tests++; if (bus.irq !== 1'b0) begin $display("FAIL ei_poll_old_ie: got %b expected 0", bus.irq); n_fail++; end
      do_poll();
      n_tests++; if (bus.irq !== 1'b1 || bus.ivec !== 16'h003C) begin $display("FAIL r75_win: got irq=%b ivec=%h expected irq=1 ivec=003C", bus.irq, bus.ivec); n_fail++; end
      do_ack(); tick(1);
      n_tests++; if (bus.rim_data !== 8'h00) begin $display("FAIL rim_after_r75: got %h expected 00", bus.rim_data); n_fail++; end
      trap = 1'b0; rst75 = 1'b0; intr = 1'b0; tick(3);
   endtask

   task automatic test_mask75();
      do_ei(); do_poll();
      do_sim(8'h0C);
      rst75 = 1'b1; tick(4);
      do_poll();
      n_tests++; if (bus.irq !== 1'b0) begin $display("FAIL r75_masked: got %b expected 0", bus.irq); n_fail++; end
      n_tests++; if (bus.rim_data !== 8'h4C) begin $display("FAIL rim_r75_pend: got %h expected 4C", bus.rim_data); n_fail++; end
      do_sim(8'h10);
      n_tests++; if (bus.rim_data !== 8'h0C) begin $display("FAIL sim_r75_clear: got %h expected 0C", bus.rim_data); n_fail++; end
      rst75 = 1'b0; tick(3);
      rst75 = 1'b1; tick(2);
      do_sim(8'h10);
      n_tests++; if (bus.rim_data[6] !== 1'b1) begin $display("FAIL edge_beats_clear: got %b expected 1", bus.rim_data[6]); n_fail++; end
      do_sim(8'h10);
      n_tests++; if (bus.rim_data[6] !== 1'b0) begin $display("FAIL clear_after_edge: got %b expected 0", bus.rim_data[6]); n_fail++; end
      rst75 = 1'b0; tick(3);
   endtask

   task automatic test_intr();
      intr = 1'b1; tick(3);
      do_poll();
      n_tests++; if (bus.irq !== 1'b1 || bus.use_inta !== 1'b1 || bus.ivec !== 16'h0000) begin $display("FAIL intr_inta: got irq=%b use_inta=%b ivec=%h expected 1 1 0000", bus.irq, bus.use_inta, bus.ivec); n_fail++; end
      do_ack(); tick(1);
      intr = 1'b0;
      do_sim(8'h08);
      rst55 = 1'b1; tick(3);
      do_ei(); do_poll();
      n_tests++; if (bus.irq !== 1'b0) begin $display("FAIL ei_delay_r55: got %b expected 0", bus.irq); n_fail++; end
      n_tests++; if (bus.ie_out !== 1'b1) begin $display("FAIL ei_delay_ie: got %b expected 1", bus.ie_out); n_fail++; end
      do_poll();
      n_tests++; if (bus.irq !== 1'b1 || bus.ivec !== 16'h002C || bus.use_inta !== 1'b0) begin $display("FAIL r55_win: got irq=%b ivec=%h use_inta=%b expected 1 002C 0", bus.irq, bus.ivec, bus.use_inta); n_fail++; end
      do_ack(); tick(1);
      rst55 = 1'b0; tick(3);
   endtask

   task automatic test_di();
      bus.ei_op = 1'b1; bus.di_op = 1'b1; tick(1); bus.ei_op = 1'b0; bus.di_op = 1'b0;
      do_poll();
      n_tests++; if (bus.ie_out !== 1'b0) begin $display("FAIL di_beats_ei: got %b expected 0", bus.ie_out); n_fail++; end
      do_ei(); do_di(); do_poll();
      n_tests++; if (bus.ie_out !== 1'b0) begin $display("FAIL di_cancels_pend: got %b expected 0", bus.ie_out); n_fail++; end
      do_ei(); do_poll(); do_di();
      n_tests++; if (bus.ie_out !== 1'b0) begin $display("FAIL di_clears_ie: got %b expected 0", bus.ie_out); n_fail++; end
   endtask

   task automatic test_serial_reset();
      do_sim(8'hC0);
      n_tests++; if (sod !== c_SER) begin $display("FAIL sod_set: got %b expected %b", sod, c_SER); n_fail++; end
      sid = 1'b1; tick(3);
      n_tests++; if (bus.rim_data !== {c_SER, 7'h00}) begin $display("FAIL rim_sid: got %h expected %h", bus.rim_data, {c_SER, 7'h00}); n_fail++; end
      do_ei(); do_poll();
      rst65 = 1'b1; tick(3);
      do_poll();
      n_tests++; if (bus.irq !== 1'b1) begin $display("FAIL pre_rst_irq: got %b expected 1", bus.irq); n_fail++; end
      rst = 1'b1; #1;
      n_tests++; if (bus.irq !== 1'b0) begin $display("FAIL rst_async_irq: got %b expected 0", bus.irq); n_fail++; end
      n_tests++; if (bus.rim_data !== 8'h07) begin $display("FAIL rst_rim: got %h expected 07", bus.rim_data); n_fail++; end
      n_tests++; if (sod !== 1'b0 || bus.ie_out !== 1'b0 || bus.ivec !== 16'h0000) begin $display("FAIL rst_state: got sod=%b ie=%b ivec=%h expected 0 0 0000", sod, bus.ie_out, bus.ivec); n_fail++; end
      tick(2);
      rst65 = 1'b0; sid = 1'b0; rst = 1'b0; tick(2);
   endtask

   initial begin
      bus.poll = 1'b0; bus.ack = 1'b0; bus.ei_op = 1'b0; bus.di_op = 1'b0;
      bus.sim_wr = 1'b0; bus.sim_data = 8'h00;
      tick(2);
      rst = 1'b0;
      test_reset();
      test_rst65();
      test_priority();
      test_mask75();
      test_intr();
      test_di();
      test_serial_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
